// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply/divide controller: op codes, FSM states,
// default iteration counts and small operand helpers.
package hilo_pkg;

  localparam logic [2:0] HL_NONE  = 3'd0;
  localparam logic [2:0] HL_MULT  = 3'd1;
  localparam logic [2:0] HL_MULTU = 3'd2;
  localparam logic [2:0] HL_DIV   = 3'd3;
  localparam logic [2:0] HL_DIVU  = 3'd4;
  localparam logic [2:0] HL_MTHI  = 3'd5;
  localparam logic [2:0] HL_MTLO  = 3'd6;

  localparam int MUL_CYCLES_DEF = 2;
  localparam int DIV_ITERS_DEF  = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } hl_state_e;

  // Magnitude of a 32-bit operand; only negates when the op is signed.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic is_muldiv(input logic [2:0] op);
    return (op >= HL_MULT) && (op <= HL_DIVU);
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// EX-stage HI/LO bus: instruction request from EX, stall/done/HI/LO back, plus FSM state for observation.
// Handshake: an op is taken in IDLE when op_valid is high and flush is low; while stall_out is high EX
// must hold op/src_a/src_b stable, and the instruction advances in the cycle done (or no stall) is seen.
interface hilo_muldiv_ctrl_if;
  import hilo_pkg::*;

  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stall_out;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  hl_state_e   state_dbg;

  modport master (
    output op_valid, op, src_a, src_b, flush,
    input  stall_out, done, hi, lo, state_dbg
  );

  modport slave (
    input  op_valid, op, src_a, src_b, flush,
    output stall_out, done, hi, lo, state_dbg
  );

endinterface

// File: rtl/hilo_muldiv_ctrl_div_iter_radix2.sv
// Unsigned restoring radix-2 divider, one quotient bit per clock. Sign handling lives in the caller;
// quotient/remainder present the values that the current iteration produces at the next edge.
module div_iter_radix2 #(
  parameter int W     = 32,
  parameter int ITERS = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         last_iter,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(ITERS + 1);

  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  logic [W:0]    shifted;
  logic [W:0]    diff;
  logic          fits;
  logic [W-1:0]  rem_step;
  logic [W-1:0]  quo_step;

  // quo_q starts as the dividend and shifts its bits into the remainder as quotient bits fill from the right.
  always_comb begin
    shifted  = {rem_q, quo_q[W-1]};
    diff     = shifted - {1'b0, dvs_q};
    fits     = ~diff[W];
    rem_step = fits ? diff[W-1:0] : shifted[W-1:0];
    quo_step = {quo_q[W-2:0], fits};

    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;

    if (start) begin
      rem_d  = '0;
      quo_d  = dividend;
      dvs_d  = divisor;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = rem_step;
      quo_d = quo_step;
      cnt_d = cnt_q + CW'(1);
      if (last_iter) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end

    if (abort) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign last_iter = (cnt_q == CW'(ITERS - 1));
  assign quotient  = quo_step;
  assign remainder = rem_step;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner and multi-cycle MULT/MULTU/DIV/DIVU sequencer for EX; also handles MTHI/MTLO.
// Optional HILO_BYPASS_EN: hi/lo outputs forward the value being written in the same cycle.
module hilo_muldiv_ctrl
  import hilo_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_ITERS  = DIV_ITERS_DEF
) (
  input logic               clk,
  input logic               resetn,
  hilo_muldiv_ctrl_if.slave bus
);

  localparam int MCW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  hl_state_e      state_q, state_d;
  logic [MCW-1:0] cnt_q, cnt_d;
  logic [31:0]    hi_q, hi_d;
  logic [31:0]    lo_q, lo_d;
  logic [31:0]    a_q, a_d;
  logic [31:0]    b_q, b_d;
  logic           signed_q, signed_d;
  logic           q_neg_q, q_neg_d;
  logic           r_neg_q, r_neg_d;
  logic           dz_q, dz_d;

  logic           op_div, op_signed, op_mt;
  logic           accept, mt_wr, div_start;
  logic           div_busy, div_last;
  logic [31:0]    div_quo, div_rem;
  logic signed [63:0] prod_s;
  logic [63:0]    prod_u, prod;

  always_comb begin
    op_div    = (bus.op == HL_DIV) || (bus.op == HL_DIVU);
    op_signed = (bus.op == HL_MULT) || (bus.op == HL_DIV);
    op_mt     = (bus.op == HL_MTHI) || (bus.op == HL_MTLO);
    accept    = (state_q == ST_IDLE) && bus.op_valid && !bus.flush && is_muldiv(bus.op);
    mt_wr     = (state_q == ST_IDLE) && bus.op_valid && !bus.flush && op_mt;
    div_start = accept && op_div;
  end

  div_iter_radix2 #(
    .W     (32),
    .ITERS (DIV_ITERS)
  ) u_div (
    .clk       (clk),
    .rst_n     (resetn),
    .start     (div_start),
    .abort     (bus.flush),
    .dividend  (abs32(bus.src_a, op_signed)),
    .divisor   (abs32(bus.src_b, op_signed)),
    .busy      (div_busy),
    .last_iter (div_last),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Operands are held for the whole MUL state, so the product has MUL_CYCLES to settle.
  always_comb begin
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    prod   = signed_q ? prod_s : prod_u;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    dz_d     = dz_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d      = bus.src_a;
          b_d      = bus.src_b;
          signed_d = op_signed;
          q_neg_d  = op_signed && (bus.src_a[31] ^ bus.src_b[31]);
          r_neg_d  = op_signed && bus.src_a[31];
          dz_d     = (bus.src_b == 32'd0);
          cnt_d    = '0;
          state_d  = op_div ? ST_DIV : ST_MUL;
        end else if (mt_wr) begin
          if (bus.op == HL_MTHI) hi_d = bus.src_a;
          else                   lo_d = bus.src_a;
        end
      end
      ST_MUL: begin
        if (cnt_q == MCW'(MUL_CYCLES - 1)) begin
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + MCW'(1);
        end
      end
      ST_DIV: begin
        if (div_busy && div_last) begin
          // Divide by zero still completes, but leaves HI/LO untouched.
          if (!dz_q) begin
            lo_d = q_neg_q ? (~div_quo + 32'd1) : div_quo;
            hi_d = r_neg_q ? (~div_rem + 32'd1) : div_rem;
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A flushed instruction never reaches HI/LO, even on its completion edge.
    if (bus.flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      dz_q     <= dz_d;
    end
  end

  assign bus.stall_out = accept || (state_q == ST_MUL) || (state_q == ST_DIV);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.state_dbg = state_q;

`ifdef HILO_BYPASS_EN
  // hi_d/lo_d equal the registers except in a cycle that commits a new value.
  assign bus.hi = hi_d;
  assign bus.lo = lo_d;
`else
  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
`endif

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: expected HI/LO for each MUL/DIV is queued at issue and
// popped by a monitor on every done pulse; stall lengths, flush, MTHI/MTLO and reset are checked inline.
module tb_hilo_muldiv_ctrl;
  import hilo_pkg::*;

  localparam int MULC = MUL_CYCLES_DEF;

  logic clk;
  logic resetn;

  hilo_muldiv_ctrl_if bus ();

  hilo_muldiv_ctrl #(
    .MUL_CYCLES (MUL_CYCLES_DEF),
    .DIV_ITERS  (DIV_ITERS_DEF)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic [31:0] m_hi, m_lo;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, want finished", $time);
    $fatal(1, "global timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (resetn && bus.done) begin
      if (exp_q.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL unexpected_done: got done=1 hi=0x%0h lo=0x%0h, want no done", bus.hi, bus.lo);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_hi", {32'd0, bus.hi}, {32'd0, mon_e[63:32]});
        check("done_lo", {32'd0, bus.lo}, {32'd0, mon_e[31:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Drives an op at the current time and follows it to done. With keep set, op_valid stays high
  // so the caller can present the next instruction in the DONE cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input int estall,
                        input bit keep);
    int          stalls;
    bit          seen;
    logic [31:0] lo_last, old_lo, exp_last;
    bus.op_valid = 1'b1;
    bus.op       = o;
    bus.src_a    = a;
    bus.src_b    = b;
    exp_q.push_back({ehi, elo});
    old_lo  = m_lo;
    lo_last = bus.lo;
    stalls  = 0;
    seen    = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
      else if (bus.stall_out) begin
        stalls++;
        lo_last = bus.lo;
      end
    end
    check("done_seen", {63'd0, seen}, 64'd1);
    check("stall_cycles", 64'(stalls), 64'(estall));
    check("stall_in_done", {63'd0, bus.stall_out}, 64'd0);
`ifdef HILO_BYPASS_EN
    exp_last = elo;
`else
    exp_last = old_lo;
`endif
    check("lo_last_stall_cycle", {32'd0, lo_last}, {32'd0, exp_last});
    if (!keep) begin
      bus.op_valid = 1'b0;
      bus.op       = HL_NONE;
    end
    m_hi = ehi;
    m_lo = elo;
  endtask

  task automatic mt_write(input logic [2:0] o, input logic [31:0] d);
    logic [31:0] exp_now;
    @(posedge clk); #1;
    bus.op_valid = 1'b1;
    bus.op       = o;
    bus.src_a    = d;
    @(negedge clk);
    check("mt_stall", {63'd0, bus.stall_out}, 64'd0);
`ifdef HILO_BYPASS_EN
    exp_now = d;
`else
    exp_now = (o == HL_MTHI) ? m_hi : m_lo;
`endif
    check("mt_write_cycle", {32'd0, (o == HL_MTHI) ? bus.hi : bus.lo}, {32'd0, exp_now});
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    bus.op       = HL_NONE;
    if (o == HL_MTHI) m_hi = d;
    else              m_lo = d;
    @(negedge clk);
    check("mt_hi", {32'd0, bus.hi}, {32'd0, m_hi});
    check("mt_lo", {32'd0, bus.lo}, {32'd0, m_lo});
  endtask

  task automatic idle_nop(input logic [2:0] o, input logic fl, input string name);
    @(posedge clk); #1;
    bus.op_valid = 1'b1;
    bus.op       = o;
    bus.src_a    = 32'h0BAD_0BAD;
    bus.src_b    = 32'd3;
    bus.flush    = fl;
    @(negedge clk);
    check({name, "_stall"}, {63'd0, bus.stall_out}, 64'd0);
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    bus.op       = HL_NONE;
    bus.flush    = 1'b0;
    @(negedge clk);
    check({name, "_state"}, 64'(bus.state_dbg), 64'(ST_IDLE));
    check({name, "_hi"}, {32'd0, bus.hi}, {32'd0, m_hi});
    check({name, "_lo"}, {32'd0, bus.lo}, {32'd0, m_lo});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    resetn       = 1'b0;
    bus.op_valid = 1'b0;
    bus.op       = HL_NONE;
    bus.src_a    = '0;
    bus.src_b    = '0;
    bus.flush    = 1'b0;
    m_hi = '0;
    m_lo = '0;

    repeat (2) @(negedge clk);
    check("rst_state", 64'(bus.state_dbg), 64'(ST_IDLE));
    check("rst_hi", {32'd0, bus.hi}, 64'd0);
    check("rst_lo", {32'd0, bus.lo}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_stall", {63'd0, bus.stall_out}, 64'd0);
    @(posedge clk); #1 resetn = 1'b1;

    // Multiplies: -2 * 3 signed and 0xFFFFFFFE * 3 unsigned.
    @(posedge clk); #1;
    run_op(HL_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1 + MULC, 1'b0);
    @(posedge clk); #1;
    run_op(HL_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 1 + MULC, 1'b0);

    // Divides with every sign combination plus the MIN / -1 wrap.
    @(posedge clk); #1;
    run_op(HL_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0);
    @(posedge clk); #1;
    run_op(HL_DIVU, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 33, 1'b0);
    @(posedge clk); #1;
    run_op(HL_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33, 1'b0);
    @(posedge clk); #1;
    run_op(HL_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 33, 1'b0);
    @(posedge clk); #1;
    run_op(HL_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33, 1'b0);

    // Divide by zero leaves the preloaded HI/LO in place.
    mt_write(HL_MTHI, 32'hAAAA_0000);
    mt_write(HL_MTLO, 32'h0000_5555);
    @(posedge clk); #1;
    run_op(HL_DIVU, 32'd5, 32'd0, 32'hAAAA_0000, 32'h0000_5555, 33, 1'b0);

    // Flush on the 10th stall cycle of a DIV.
    @(posedge clk); #1;
    bus.op_valid = 1'b1;
    bus.op       = HL_DIV;
    bus.src_a    = 32'd100;
    bus.src_b    = 32'd7;
    repeat (10) @(negedge clk);
    check("flush_pre_stall", {63'd0, bus.stall_out}, 64'd1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush    = 1'b0;
    bus.op_valid = 1'b0;
    bus.op       = HL_NONE;
    @(negedge clk);
    check("flush_state", 64'(bus.state_dbg), 64'(ST_IDLE));
    check("flush_stall", {63'd0, bus.stall_out}, 64'd0);
    check("flush_done", {63'd0, bus.done}, 64'd0);
    repeat (40) @(negedge clk);
    check("flush_hi", {32'd0, bus.hi}, {32'd0, m_hi});
    check("flush_lo", {32'd0, bus.lo}, {32'd0, m_lo});
    mt_write(HL_MTLO, 32'h1234_5678);

    // Flush in IDLE blocks acceptance; NONE and reserved ops do nothing.
    idle_nop(HL_DIV, 1'b1, "idle_flush");
    idle_nop(HL_NONE, 1'b0, "op_none");
    idle_nop(3'd7, 1'b0, "op_rsvd");

    // Back-to-back: MULTU is presented in the DIVU DONE cycle with op_valid held.
    @(posedge clk); #1;
    run_op(HL_DIVU, 32'd9, 32'd3, 32'h0000_0000, 32'h0000_0003, 33, 1'b1);
    run_op(HL_MULTU, 32'd4, 32'd5, 32'h0000_0000, 32'h0000_0014, 1 + MULC, 1'b0);

    // Asynchronous reset in the middle of a DIV.
    @(posedge clk); #1;
    bus.op_valid = 1'b1;
    bus.op       = HL_DIVU;
    bus.src_a    = 32'd100;
    bus.src_b    = 32'd7;
    repeat (5) @(negedge clk);
    bus.op_valid = 1'b0;
    bus.op       = HL_NONE;
    #2 resetn = 1'b0;
    #1;
    check("midrst_state", 64'(bus.state_dbg), 64'(ST_IDLE));
    check("midrst_stall", {63'd0, bus.stall_out}, 64'd0);
    check("midrst_hi", {32'd0, bus.hi}, 64'd0);
    check("midrst_lo", {32'd0, bus.lo}, 64'd0);
    @(posedge clk); #1 resetn = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_state", 64'(bus.state_dbg), 64'(ST_IDLE));

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
